// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and pipe_hazard_ctrl (slave).
interface pipe_hazard_ctrl_if #(
    parameter int ADDR_W = 64,
    parameter int NSTAGE = 5
);
    logic              ex_jump_valid;
    logic [ADDR_W-1:0] ex_jump_addr;
    logic              trap_valid;
    logic [ADDR_W-1:0] trap_addr;
    logic [NSTAGE-1:0] hold_req;
    logic              pc_jump_valid;
    logic [ADDR_W-1:0] pc_jump_addr;
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] flush;
    logic              busy;

    modport master (
        output ex_jump_valid, ex_jump_addr, trap_valid, trap_addr, hold_req,
        input  pc_jump_valid, pc_jump_addr, stall, flush, busy
    );

    modport slave (
        input  ex_jump_valid, ex_jump_addr, trap_valid, trap_addr, hold_req,
        output pc_jump_valid, pc_jump_addr, stall, flush, busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush/redirect controller. Optional perf counters under PIPE_HAZARD_PERF_EN.
// Redirects issue combinationally (0 latency) when EX is free, otherwise they wait in PEND.
module pipe_hazard_ctrl #(
    parameter int ADDR_W    = 64,
    parameter int NSTAGE    = 5,
    parameter int EX_IDX    = 2,
    parameter int FLUSH_LEN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef PIPE_HAZARD_PERF_EN
    output logic [31:0]          perf_stall_cyc,
    output logic [31:0]          perf_redirect_cnt,
`endif
    pipe_hazard_ctrl_if.slave    bus
);
    localparam int CNT_W = $clog2(FLUSH_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_LEN - 1);
    localparam logic [NSTAGE-1:0] FRONT_MASK = {NSTAGE{1'b1}} >> (NSTAGE - 1 - EX_IDX);

    typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, FLUSH = 2'd2} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NSTAGE-1:0] stall_base_s, flush_base_s;
    logic              ex_stalled_s, req_s, issue_s, front_flush_s;
    logic [ADDR_W-1:0] req_addr_s, issue_addr_s;

    // Hold chain: every stage at or behind the oldest busy stage stalls, a bubble goes after it.
    always_comb begin
        stall_base_s = '0;
        flush_base_s = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            stall_base_s[i] = |(bus.hold_req >> i);
        end
        for (int i = 1; i < NSTAGE; i++) begin
            flush_base_s[i] = bus.hold_req[i-1] & ~stall_base_s[i];
        end
    end

    assign ex_stalled_s = stall_base_s[EX_IDX];
    assign req_s        = bus.trap_valid | ((state_q == IDLE) & bus.ex_jump_valid);
    assign req_addr_s   = bus.trap_valid ? bus.trap_addr : bus.ex_jump_addr;

    // Redirect FSM next-state and issue decision.
    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        cnt_d         = cnt_q;
        issue_s       = 1'b0;
        issue_addr_s  = '0;
        front_flush_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s && !ex_stalled_s) begin
                    issue_s      = 1'b1;
                    issue_addr_s = req_addr_s;
                    cnt_d        = CNT_RELOAD;
                    state_d      = (FLUSH_LEN > 1) ? FLUSH : IDLE;
                end else if (req_s) begin
                    pend_d  = req_addr_s;
                    state_d = PEND;
                end else begin
                    state_d = IDLE;
                end
            end
            PEND: begin
                if (!ex_stalled_s) begin
                    issue_s      = 1'b1;
                    issue_addr_s = bus.trap_valid ? bus.trap_addr : pend_q;
                    cnt_d        = CNT_RELOAD;
                    state_d      = (FLUSH_LEN > 1) ? FLUSH : IDLE;
                end else begin
                    pend_d = bus.trap_valid ? bus.trap_addr : pend_q;
                end
            end
            FLUSH: begin
                front_flush_s = 1'b1;
                if (bus.trap_valid && !ex_stalled_s) begin
                    issue_s      = 1'b1;
                    issue_addr_s = bus.trap_addr;
                    cnt_d        = CNT_RELOAD;
                end else if (bus.trap_valid) begin
                    pend_d  = bus.trap_addr;
                    state_d = PEND;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output assembly; a flushed stage never also reports stall.
    always_comb begin
        bus.pc_jump_valid = 1'b0;
        bus.pc_jump_addr  = '0;
        bus.flush         = '0;
        bus.stall         = '0;
        bus.busy          = 1'b0;
        if (rst) begin
            bus.busy = 1'b0;
        end else begin
            bus.pc_jump_valid = issue_s;
            bus.pc_jump_addr  = issue_addr_s;
            bus.flush         = flush_base_s | ((issue_s | front_flush_s) ? FRONT_MASK : '0);
            bus.stall         = stall_base_s & ~bus.flush;
            bus.busy          = (state_q != IDLE);
        end
    end

    // FSM state, pending redirect and flush stretch counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_redir_q;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= 32'd0;
            perf_redir_q <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_q + {31'd0, bus.stall[0]};
            perf_redir_q <= perf_redir_q + {31'd0, bus.pc_jump_valid};
        end
    end

    assign perf_stall_cyc    = perf_stall_q;
    assign perf_redirect_cnt = perf_redir_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: one instance with FLUSH_LEN=1, one with FLUSH_LEN=3.
module tb_pipe_hazard_ctrl;
    typedef struct packed {
        logic        pcv;
        logic [63:0] addr;
        logic [4:0]  stall;
        logic [4:0]  flush;
        logic        busy;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    obs_t exp_q[$];
    obs_t obs_q[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.ADDR_W(64), .NSTAGE(5)) bus1 ();
    pipe_hazard_ctrl_if #(.ADDR_W(64), .NSTAGE(5)) bus3 ();

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] ps1, pr1, ps3, pr3;
`endif

    pipe_hazard_ctrl #(.ADDR_W(64), .NSTAGE(5), .EX_IDX(2), .FLUSH_LEN(1)) u_dut1 (
        .clk(clk), .rst(rst),
`ifdef PIPE_HAZARD_PERF_EN
        .perf_stall_cyc(ps1), .perf_redirect_cnt(pr1),
`endif
        .bus(bus1)
    );

    pipe_hazard_ctrl #(.ADDR_W(64), .NSTAGE(5), .EX_IDX(2), .FLUSH_LEN(3)) u_dut3 (
        .clk(clk), .rst(rst),
`ifdef PIPE_HAZARD_PERF_EN
        .perf_stall_cyc(ps3), .perf_redirect_cnt(pr3),
`endif
        .bus(bus3)
    );

    function automatic obs_t mk(input logic pcv, input logic [63:0] addr,
                                input logic [4:0] st, input logic [4:0] fl, input logic busy);
        obs_t r;
        r.pcv = pcv; r.addr = addr; r.stall = st; r.flush = fl; r.busy = busy;
        return r;
    endfunction

    // One cycle of stimulus on the selected instance (other instance idles); records expected and observed.
    task automatic drive(input bit sel3, input logic r, input logic ev, input logic [63:0] ea,
                         input logic tv, input logic [63:0] ta, input logic [4:0] hr, input obs_t e);
        @(posedge clk);
        #1;
        rst = r;
        bus1.ex_jump_valid = sel3 ? 1'b0 : ev;  bus1.ex_jump_addr = ea;
        bus1.trap_valid    = sel3 ? 1'b0 : tv;  bus1.trap_addr    = ta;
        bus1.hold_req      = sel3 ? 5'd0 : hr;
        bus3.ex_jump_valid = sel3 ? ev : 1'b0;  bus3.ex_jump_addr = ea;
        bus3.trap_valid    = sel3 ? tv : 1'b0;  bus3.trap_addr    = ta;
        bus3.hold_req      = sel3 ? hr : 5'd0;
        exp_q.push_back(e);
        @(negedge clk);
        if (sel3) obs_q.push_back(mk(bus3.pc_jump_valid, bus3.pc_jump_addr, bus3.stall, bus3.flush, bus3.busy));
        else      obs_q.push_back(mk(bus1.pc_jump_valid, bus1.pc_jump_addr, bus1.stall, bus1.flush, bus1.busy));
    endtask

    task automatic test_reset();
        obs_t e, o;
        int n = 0;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 5'd0, mk(1'b0, 64'd0, 5'd0, 5'd0, 1'b0));
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'd0, mk(1'b0, 64'd0, 5'd0, 5'd0, 1'b0));
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'd0, mk(1'b0, 64'd0, 5'd0, 5'd0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset#%0d got pcv=%b addr=%h st=%b fl=%b busy=%b want pcv=%b addr=%h st=%b fl=%b busy=%b",
                         n, o.pcv, o.addr, o.stall, o.flush, o.busy, e.pcv, e.addr, e.stall, e.flush, e.busy);
            end
        end
    endtask

    task automatic test_hold_chain();
        obs_t e, o;
        int n = 0;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'b01000, mk(1'b0, 64'd0, 5'b01111, 5'b10000, 1'b0));
        drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'b00000, mk(1'b0, 64'd0, 5'b00000, 5'b00000, 1'b0));
        drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'b10010, mk(1'b0, 64'd0, 5'b11111, 5'b00000, 1'b0));
        drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'b00001, mk(1'b0, 64'd0, 5'b00001, 5'b00010, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
            if (o !== e) begin
                failures++;
                $display("FAIL hold#%0d got pcv=%b addr=%h st=%b fl=%b busy=%b want pcv=%b addr=%h st=%b fl=%b busy=%b",
                         n, o.pcv, o.addr, o.stall, o.flush, o.busy, e.pcv, e.addr, e.stall, e.flush, e.busy);
            end
        end
    endtask

    task automatic test_immediate_jump();
        obs_t e, o;
        int n = 0;
        drive(1'b0, 1'b0, 1'b1, 64'h8000_0100, 1'b0, 64'd0, 5'd0, mk(1'b1, 64'h8000_0100, 5'd0, 5'b00111, 1'b0));
        drive(1'b0, 1'b0, 1'b0, 64'h8000_0100, 1'b0, 64'd0, 5'd0, mk(1'b0, 64'd0, 5'd0, 5'd0, 1'b0));
        // Hold behind EX does not block a jump; the front flush overrides those stalls.
        drive(1'b0, 1'b0, 1'b1, 64'h0000_0040, 1'b0, 64'd0, 5'b00010, mk(1'b1, 64'h0000_0040, 5'd0, 5'b00111, 1'b0));
        drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'd0, mk(1'b0, 64'd0, 5'd0, 5'd0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
            if (o !== e) begin
                failures++;
                $display("FAIL jump#%0d got pcv=%b addr=%h st=%b fl=%b busy=%b want pcv=%b addr=%h st=%b fl=%b busy=%b",
                         n, o.pcv, o.addr, o.stall, o.flush, o.busy, e.pcv, e.addr, e.stall, e.flush, e.busy);
            end
        end
    endtask

    task automatic test_deferred_trap();
        obs_t e, o;
        int n = 0;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 64'h8000_0004, 5'b01000, mk(1'b0, 64'd0, 5'b01111, 5'b10000, 1'b0));
        drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'b01000, mk(1'b0, 64'd0, 5'b01111, 5'b10000, 1'b1));
        drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'b01000, mk(1'b0, 64'd0, 5'b01111, 5'b10000, 1'b1));
        drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'b00000, mk(1'b1, 64'h8000_0004, 5'd0, 5'b00111, 1'b1));
        drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'b00000, mk(1'b0, 64'd0, 5'd0, 5'd0, 1'b0));
        // Reset while pending discards the buffered redirect.
        drive(1'b0, 1'b0, 1'b1, 64'h500, 1'b0, 64'd0, 5'b01000, mk(1'b0, 64'd0, 5'b01111, 5'b10000, 1'b0));
        drive(1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 5'b01000, mk(1'b0, 64'd0, 5'd0, 5'd0, 1'b0));
        drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'b00000, mk(1'b0, 64'd0, 5'd0, 5'd0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
            if (o !== e) begin
                failures++;
                $display("FAIL deferred#%0d got pcv=%b addr=%h st=%b fl=%b busy=%b want pcv=%b addr=%h st=%b fl=%b busy=%b",
                         n, o.pcv, o.addr, o.stall, o.flush, o.busy, e.pcv, e.addr, e.stall, e.flush, e.busy);
            end
        end
    endtask

    task automatic test_priority();
        obs_t e, o;
        int n = 0;
        drive(1'b0, 1'b0, 1'b1, 64'h100, 1'b0, 64'd0, 5'b01000, mk(1'b0, 64'd0, 5'b01111, 5'b10000, 1'b0));
        drive(1'b0, 1'b0, 1'b1, 64'h300, 1'b0, 64'd0, 5'b01000, mk(1'b0, 64'd0, 5'b01111, 5'b10000, 1'b1));
        drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 64'h200, 5'b01000, mk(1'b0, 64'd0, 5'b01111, 5'b10000, 1'b1));
        drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'b00000, mk(1'b1, 64'h200, 5'd0, 5'b00111, 1'b1));
        drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'b00000, mk(1'b0, 64'd0, 5'd0, 5'd0, 1'b0));
        drive(1'b0, 1'b0, 1'b1, 64'h100, 1'b1, 64'h200, 5'b00000, mk(1'b1, 64'h200, 5'd0, 5'b00111, 1'b0));
        drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'b00000, mk(1'b0, 64'd0, 5'd0, 5'd0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
            if (o !== e) begin
                failures++;
                $display("FAIL priority#%0d got pcv=%b addr=%h st=%b fl=%b busy=%b want pcv=%b addr=%h st=%b fl=%b busy=%b",
                         n, o.pcv, o.addr, o.stall, o.flush, o.busy, e.pcv, e.addr, e.stall, e.flush, e.busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        int n = 0;
        logic [63:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 64'h1000 * (i + 1);
            drive(1'b0, 1'b0, 1'b1, a, 1'b0, 64'd0, 5'd0, mk(1'b1, a, 5'd0, 5'b00111, 1'b0));
        end
        drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'd0, mk(1'b0, 64'd0, 5'd0, 5'd0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b#%0d got pcv=%b addr=%h st=%b fl=%b busy=%b want pcv=%b addr=%h st=%b fl=%b busy=%b",
                         n, o.pcv, o.addr, o.stall, o.flush, o.busy, e.pcv, e.addr, e.stall, e.flush, e.busy);
            end
        end
    endtask

    task automatic test_flush_len3();
        obs_t e, o;
        int n = 0;
        drive(1'b1, 1'b0, 1'b1, 64'hA00, 1'b0, 64'd0, 5'd0, mk(1'b1, 64'hA00, 5'd0, 5'b00111, 1'b0));
        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'd0, mk(1'b0, 64'd0, 5'd0, 5'b00111, 1'b1));
        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 64'hB00, 5'd0, mk(1'b1, 64'hB00, 5'd0, 5'b00111, 1'b1));
        drive(1'b1, 1'b0, 1'b1, 64'hD00, 1'b0, 64'd0, 5'd0, mk(1'b0, 64'd0, 5'd0, 5'b00111, 1'b1));
        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'd0, mk(1'b0, 64'd0, 5'd0, 5'b00111, 1'b1));
        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'd0, mk(1'b0, 64'd0, 5'd0, 5'd0, 1'b0));
        // Trap during the stretch while EX is held goes to PEND.
        drive(1'b1, 1'b0, 1'b1, 64'hA00, 1'b0, 64'd0, 5'd0, mk(1'b1, 64'hA00, 5'd0, 5'b00111, 1'b0));
        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 64'hC00, 5'b01000, mk(1'b0, 64'd0, 5'b01000, 5'b10111, 1'b1));
        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'b01000, mk(1'b0, 64'd0, 5'b01111, 5'b10000, 1'b1));
        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'b00000, mk(1'b1, 64'hC00, 5'd0, 5'b00111, 1'b1));
        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'b00000, mk(1'b0, 64'd0, 5'd0, 5'b00111, 1'b1));
        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'b00000, mk(1'b0, 64'd0, 5'd0, 5'b00111, 1'b1));
        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 5'b00000, mk(1'b0, 64'd0, 5'd0, 5'd0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
            if (o !== e) begin
                failures++;
                $display("FAIL flush3#%0d got pcv=%b addr=%h st=%b fl=%b busy=%b want pcv=%b addr=%h st=%b fl=%b busy=%b",
                         n, o.pcv, o.addr, o.stall, o.flush, o.busy, e.pcv, e.addr, e.stall, e.flush, e.busy);
            end
        end
    endtask

    initial begin
        bus1.ex_jump_valid = 1'b0; bus1.ex_jump_addr = 64'd0; bus1.trap_valid = 1'b0;
        bus1.trap_addr = 64'd0; bus1.hold_req = 5'd0;
        bus3.ex_jump_valid = 1'b0; bus3.ex_jump_addr = 64'd0; bus3.trap_valid = 1'b0;
        bus3.trap_addr = 64'd0; bus3.hold_req = 5'd0;
        test_reset();
        test_hold_chain();
        test_immediate_jump();
        test_deferred_trap();
        test_priority();
        test_back_to_back();
        test_flush_len3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
